// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse pattern generator: the 2-bit symbol codes
// carried in each Pattern slot, the length of each tone/gap element in Morse
// units, and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package morse_pkg;

  // Symbol codes, one per 2-bit Pattern slot.
  typedef enum logic [1:0] {
    SYM_END  = 2'b00,
    SYM_DOT  = 2'b01,
    SYM_DASH = 2'b10,
    SYM_WORD = 2'b11
  } sym_e;

  // Element lengths in Morse units. They fit the 3-bit unit counter.
  localparam logic [2:0] DOT_UNITS  = 3'd1;
  localparam logic [2:0] DASH_UNITS = 3'd3;
  localparam logic [2:0] GAP_UNITS  = 3'd1;
  localparam logic [2:0] WORD_UNITS = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ON,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage : morse_pkg

// File: rtl/morse_unit_tick.sv
// -----------------------------------------------------------------------------
// morse_unit_tick
// Millisecond prescaler followed by a millisecond counter. Emits a one-cycle
// pulse on the last clock cycle of every Morse unit
// (TICKS_PER_MS * UNIT_MS cycles). A synchronous clear restarts the unit so
// that each tone/gap phase begins on a fresh unit boundary.
//
// Ports:
//   CLK          in   system clock
//   RST          in   asynchronous active-high reset
//   i_clr        in   synchronous clear of both counters
//   o_unit_tick  out  high on the final cycle of each unit
// -----------------------------------------------------------------------------
module morse_unit_tick #(
  parameter int TICKS_PER_MS = 50000,
  parameter int UNIT_MS      = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  output logic o_unit_tick
);

  // A 1-cycle or 1-ms unit still needs a 1-bit counter.
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int MW = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [MW-1:0] MS_LAST  = MW'(UNIT_MS - 1);

  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_ms;
  logic          w_ms_tick;

  assign w_ms_tick   = (r_pre == PRE_LAST);
  assign o_unit_tick = w_ms_tick && (r_ms == MS_LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (i_clr) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else begin
      r_pre <= w_ms_tick ? '0 : r_pre + PW'(1);
      if (o_unit_tick) begin
        r_ms <= '0;
      end else if (w_ms_tick) begin
        r_ms <= r_ms + MW'(1);
      end
    end
  end

endmodule : morse_unit_tick

// File: rtl/morse_pattern_gen.sv
// -----------------------------------------------------------------------------
// morse_pattern_gen
// Plays a latched list of up to MAX_SYMS Morse symbols (dot, dash, word gap)
// on a single pin. One unit U = TICKS_PER_MS * UNIT_MS clock cycles.
// Each symbol is preceded by a one-cycle LOAD that decodes the next slot.
//
// Optional build macro MORSE_REPEAT_EN: adds Repeat_Sig. When the end of the
// list is reached with Repeat_Sig high, Done_Sig pulses, the pin stays off
// for a 7U inter-message gap, and the originally latched list is replayed
// with Busy held high.
//
// Ports:
//   CLK         in   system clock
//   RST         in   asynchronous active-high reset
//   Start_Sig   in   start request, sampled only in IDLE
//   Abort_Sig   in   synchronous abort, effective in any non-IDLE state
//   Pattern     in   symbol list, slot k = bits [2k+1:2k], slot 0 first
//   Repeat_Sig  in   (MORSE_REPEAT_EN only) loop the message
//   Busy        out  high while a message is in progress
//   Done_Sig    out  one-cycle pulse at normal completion
//   Pin_Out     out  tone output, low while on when OUT_ACTIVE_LOW = 1
// -----------------------------------------------------------------------------
module morse_pattern_gen
  import morse_pkg::*;
#(
  parameter int TICKS_PER_MS   = 50000,
  parameter int UNIT_MS        = 100,
  parameter int MAX_SYMS       = 16,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start_Sig,
  input  logic                  Abort_Sig,
  input  logic [2*MAX_SYMS-1:0] Pattern,
`ifdef MORSE_REPEAT_EN
  input  logic                  Repeat_Sig,
`endif
  output logic                  Busy,
  output logic                  Done_Sig,
  output logic                  Pin_Out
);

  // Index must be able to reach MAX_SYMS itself.
  localparam int   IW       = $clog2(MAX_SYMS + 1);
  localparam logic TONE_OFF = (OUT_ACTIVE_LOW != 0);
  localparam logic TONE_ON  = !TONE_OFF;

  state_e                r_state;
  logic [2*MAX_SYMS-1:0] r_shift;
  logic [2*MAX_SYMS-1:0] r_latched;
  logic [IW-1:0]         r_idx;
  logic [2:0]            r_units;
  logic [2:0]            r_last;     // unit count of the current phase minus one
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pin;
  logic                  r_rep;      // end-of-list reached with repeat requested
  logic                  r_reload;   // current GAP is the inter-message gap

  logic w_repeat;
  logic w_in_phase;
  logic w_unit_tick;
  logic w_phase_end;
  logic w_clr;
  logic w_at_end;

`ifdef MORSE_REPEAT_EN
  assign w_repeat = Repeat_Sig;
`else
  assign w_repeat = 1'b0;
`endif

  assign w_in_phase  = (r_state == ST_ON) || (r_state == ST_GAP);
  assign w_phase_end = w_in_phase && w_unit_tick && (r_units == r_last);
  // Hold the unit timer cleared outside timed phases and on the last cycle of
  // a phase, so the next phase starts counting from zero.
  assign w_clr       = !w_in_phase || w_phase_end;
  assign w_at_end    = (r_shift[1:0] == SYM_END) || (r_idx == IW'(MAX_SYMS));

  morse_unit_tick #(
    .TICKS_PER_MS (TICKS_PER_MS),
    .UNIT_MS      (UNIT_MS)
  ) u_unit_tick (
    .CLK         (CLK),
    .RST         (RST),
    .i_clr       (w_clr),
    .o_unit_tick (w_unit_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_latched <= '0;
      r_idx     <= '0;
      r_units   <= '0;
      r_last    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pin     <= TONE_OFF;
      r_rep     <= 1'b0;
      r_reload  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (Abort_Sig && (r_state != ST_IDLE)) begin
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
        r_pin    <= TONE_OFF;
        r_units  <= '0;
        r_rep    <= 1'b0;
        r_reload <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (Start_Sig) begin
              r_shift   <= Pattern;
              r_latched <= Pattern;
              r_idx     <= '0;
              r_units   <= '0;
              r_reload  <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            r_units <= '0;
            if (w_at_end) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_rep   <= w_repeat;
              r_busy  <= w_repeat;
            end else begin
              case (r_shift[1:0])
                SYM_DOT: begin
                  r_state <= ST_ON;
                  r_pin   <= TONE_ON;
                  r_last  <= DOT_UNITS - 3'd1;
                end
                SYM_DASH: begin
                  r_state <= ST_ON;
                  r_pin   <= TONE_ON;
                  r_last  <= DASH_UNITS - 3'd1;
                end
                default: begin
                  r_state <= ST_GAP;
                  r_last  <= WORD_UNITS - 3'd1;
                end
              endcase
            end
          end

          ST_ON: begin
            if (w_phase_end) begin
              r_state <= ST_GAP;
              r_pin   <= TONE_OFF;
              r_units <= '0;
              r_last  <= GAP_UNITS - 3'd1;
            end else if (w_unit_tick) begin
              r_units <= r_units + 3'd1;
            end
          end

          ST_GAP: begin
            if (w_phase_end) begin
              r_state <= ST_LOAD;
              r_units <= '0;
              if (r_reload) begin
                r_shift  <= r_latched;
                r_idx    <= '0;
                r_reload <= 1'b0;
              end else begin
                r_shift <= r_shift >> 2;
                r_idx   <= r_idx + IW'(1);
              end
            end else if (w_unit_tick) begin
              r_units <= r_units + 3'd1;
            end
          end

          ST_DONE: begin
            r_units <= '0;
            if (r_rep) begin
              r_state  <= ST_GAP;
              r_last   <= WORD_UNITS - 3'd1;
              r_reload <= 1'b1;
              r_rep    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pin   <= TONE_OFF;
          end
        endcase
      end
    end
  end

  assign Busy     = r_busy;
  assign Done_Sig = r_done;
  assign Pin_Out  = r_pin;

endmodule : morse_pattern_gen

// File: tb/tb_morse_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_morse_pattern_gen
// Self-checking bench for morse_pattern_gen with U = 8 cycles and four slots.
// The expected per-cycle {Busy, Done_Sig, Pin_Out} trace is built from the
// symbol timing rules as a flat queue of cycles; outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_morse_pattern_gen;

  localparam int   T_MS   = 4;
  localparam int   U_MS   = 2;
  localparam int   N_SYMS = 4;
  localparam int   U      = T_MS * U_MS;
  localparam logic AL     = 1'b1;   // tone-off pin level

  typedef logic [2*N_SYMS-1:0] pat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  pat_t pattern;
  logic busy;
  logic done;
  logic pin;
`ifdef MORSE_REPEAT_EN
  logic repeat_sig;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];   // {busy, done, pin} for cycles 1..end of a run

  always #5 clk = ~clk;

  morse_pattern_gen #(
    .TICKS_PER_MS   (T_MS),
    .UNIT_MS        (U_MS),
    .MAX_SYMS       (N_SYMS),
    .OUT_ACTIVE_LOW (1)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .Start_Sig  (start),
    .Abort_Sig  (abort),
    .Pattern    (pattern),
`ifdef MORSE_REPEAT_EN
    .Repeat_Sig (repeat_sig),
`endif
    .Busy       (busy),
    .Done_Sig   (done),
    .Pin_Out    (pin)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push(input int n, input logic b, input logic d, input logic tone);
    for (int i = 0; i < n; i++) exp_q.push_back({b, d, tone ? ~AL : AL});
  endfunction

  // Whole-message trace: LOAD, then per symbol its tone/gap followed by the
  // next LOAD, then a single DONE cycle with Busy low.
  function automatic void build_model(input pat_t pat);
    logic [1:0] code;
    exp_q.delete();
    push(1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < N_SYMS; k++) begin
      code = pat[2*k +: 2];
      if (code == 2'b00) break;
      case (code)
        2'b01:   begin push(U, 1'b1, 1'b0, 1'b1);     push(U, 1'b1, 1'b0, 1'b0); end
        2'b10:   begin push(3 * U, 1'b1, 1'b0, 1'b1); push(U, 1'b1, 1'b0, 1'b0); end
        default: push(7 * U, 1'b1, 1'b0, 1'b0);
      endcase
      push(1, 1'b1, 1'b0, 1'b0);
    end
    push(1, 1'b0, 1'b1, 1'b0);
  endfunction

  // Full run from Start at cycle 0. With hold_start the request stays high and
  // the pattern is emptied, so a second (empty) run must follow DONE at once.
  task automatic run_pattern(input string tag, input pat_t pat, input bit hold_start);
    int n;
    build_model(pat);
    n = exp_q.size();
    // NOTE: inputs are driven with blocking assignments at the falling edge,
    // half a cycle away from the edge where the DUT samples them.
    @(negedge clk);
    pattern = pat;
    start   = 1'b1;
    check({tag, " c0"}, {busy, done, pin}, {2'b00, AL});
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (hold_start) begin
        pattern = '0;
      end else begin
        start   = 1'b0;
        pattern = pat_t'($urandom);
      end
      check($sformatf("%s c%0d", tag, c), {busy, done, pin}, exp_q[c-1]);
    end
    @(negedge clk);
    check({tag, " idle"}, {busy, done, pin}, {2'b00, AL});
    if (hold_start) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, " reaccept"}, {busy, done, pin}, {2'b10, AL});
      @(negedge clk);
      check({tag, " redone"}, {busy, done, pin}, {2'b01, AL});
      @(negedge clk);
      check({tag, " reidle"}, {busy, done, pin}, {2'b00, AL});
    end
  endtask

  task automatic abort_test();
    int a;
    a = $urandom_range(19, 42);   // inside the DASH tone of DOT,DASH
    build_model(8'b0000_1001);
    @(negedge clk);
    pattern = 8'b0000_1001;
    start   = 1'b1;
    for (int c = 1; c <= a; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("abort c%0d", c), {busy, done, pin}, exp_q[c-1]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort next", {busy, done, pin}, {2'b00, AL});
    start   = 1'b1;
    pattern = '0;
    @(negedge clk);
    start = 1'b0;
    check("abort restart load", {busy, done, pin}, {2'b10, AL});
    @(negedge clk);
    check("abort restart done", {busy, done, pin}, {2'b01, AL});
  endtask

  task automatic reset_test();
    build_model(8'b0000_1001);
    @(negedge clk);
    pattern = 8'b0000_1001;
    start   = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start   = (c == 5);
      pattern = (c == 5) ? pat_t'(8'b0000_0011) : pat_t'($urandom);
      check($sformatf("midstart c%0d", c), {busy, done, pin}, exp_q[c-1]);
    end
    #2 rst = 1'b1;
    #1 check("rst async", {busy, done, pin}, {2'b00, AL});
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst idle %0d", c), {busy, done, pin}, {2'b00, AL});
    end
  endtask

`ifdef MORSE_REPEAT_EN
  // DOT looped: one pass is LOAD + 16 + LOAD + DONE + 56-cycle gap = 75 cycles.
  // Repeat is dropped during the third gap, so the fourth pass is the last.
  task automatic repeat_test();
    int  p;
    bit  live;
    repeat_sig = 1'b1;
    @(negedge clk);
    pattern = 8'b0000_0001;
    start   = 1'b1;
    for (int c = 1; c <= 250; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 170) repeat_sig = 1'b0;
      live = (c <= 244);
      p    = (c - 1) % 75;
      check($sformatf("repeat c%0d", c), {busy, done, pin},
            {live && (c < 244), live && (p == 18),
             (live && p >= 1 && p <= 8) ? ~AL : AL});
    end
  endtask
`endif

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
`ifdef MORSE_REPEAT_EN
    repeat_sig = 1'b0;
`endif
    #1 rst = 1'b1;
    #1 check("reset", {busy, done, pin}, {2'b00, AL});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", {busy, done, pin}, {2'b00, AL});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort in idle", {busy, done, pin}, {2'b00, AL});

    run_pattern("dot",        8'b00_00_00_01, 1'b0);
    run_pattern("mixed",      8'b01_11_10_01, 1'b0);
    run_pattern("empty",      8'b00_00_00_00, 1'b0);
    run_pattern("hold_start", 8'b00_00_00_10, 1'b1);
    abort_test();
    reset_test();
    for (int i = 0; i < 10; i++) begin
      run_pattern($sformatf("rand%0d", i), pat_t'($urandom), 1'b0);
    end
`ifdef MORSE_REPEAT_EN
    repeat_test();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_morse_pattern_gen
